// File: rtl/sha256_msg_sched_if.sv
// Handshake and data bundle between a block producer, the message scheduler and the round stage.
// No logic of its own, so it adds no latency.
// Backpressure is carried by w_ready. The scheduler holds w_out and w_idx while w_ready is low.
interface sha256_msg_sched_if;
   logic         start;
   logic [511:0] block_in;
   logic         ready;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_out;
   logic [5:0]   w_idx;
   logic         done;

   // The producer/consumer side drives start, block_in and w_ready.
   modport master (
      output start, block_in, w_ready,
      input  ready, w_valid, w_out, w_idx, done
   );

   // The scheduler side drives the status and the word stream.
   modport slave (
      input  start, block_in, w_ready,
      output ready, w_valid, w_out, w_idx, done
   );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator. It expands one 512-bit block into W[0..63] with a 16-word sliding window.
// W[0] appears the cycle after start. Then one word per accepted cycle, and done pulses the cycle after W[63].
// When w_ready is low, w_out, w_idx and the window hold. start is ignored unless ready is high.
module sha256_msg_sched (
   input  logic               clk,
   input  logic               clr_n,
   sha256_msg_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] win [16];
   logic [5:0]  t;
   logic        rdy_q;
   logic        vld_q;
   logic        done_q;
   logic        xfer;
   logic [31:0] w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction

   assign xfer  = vld_q & bus.w_ready;
   assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

   // The FSM owns the window, the word index and the registered status outputs.
   // The word computed on the final transfer falls beyond W[63] and is never presented.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state  <= IDLE;
         rdy_q  <= 1'b1;
         vld_q  <= 1'b0;
         done_q <= 1'b0;
         t      <= 6'd0;
         for (int i = 0; i < 16; i++) win[i] <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < 16; i++) win[i] <= bus.block_in[511 - 32*i -: 32];
                  t     <= 6'd0;
                  rdy_q <= 1'b0;
                  vld_q <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (xfer) begin
                  for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                  win[15] <= w_new;
                  if (t == 6'd63) begin
                     vld_q  <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     t <= t + 6'd1;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               rdy_q  <= 1'b1;
               state  <= IDLE;
            end
            default: begin
               rdy_q  <= 1'b1;
               vld_q  <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready   = rdy_q;
   assign bus.w_valid = vld_q;
   assign bus.done    = done_q;
   assign bus.w_idx   = t;
   // The word bus is forced to zero whenever no valid word is presented.
   assign bus.w_out   = vld_q ? win[0] : 32'd0;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for the SHA-256 message scheduler. It uses hand-picked blocks and an array-form reference schedule.
// Inputs are driven and outputs sampled on the falling clock edge, which is half a cycle from the active edge.
// The bench covers stalls, an ignored start, an abort by reset and back-to-back blocks.
module tb_sha256_msg_sched;

   logic clk = 1'b0;
   logic clr_n;

   always #5 clk = ~clk;

   sha256_msg_sched_if bus();

   sha256_msg_sched dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0]  expw [64];
   logic [31:0]  gotw [64];
   int           done_cyc;
   logic [511:0] blk_abc;
   logic [511:0] blk_zero;
   logic [511:0] blk_c;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   task automatic build_model(input logic [511:0] blk);
      for (int i = 0; i < 16; i++) expw[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         expw[i] = s1(expw[i-2]) + expw[i-7] + s0(expw[i-15]) + expw[i-16];
   endtask

   // The caller must be positioned at a falling edge with the DUT idle.
   // A stall_at, inj_at or abort_at value of -1 disables that event.
   task automatic run_seq(input string name, input logic [511:0] blk,
                          input int stall_at, input int inj_at, input int abort_at);
      int cyc;
      build_model(blk);
      check({name, "_ready_idle"}, bus.ready, 32'd1);
      bus.start    = 1'b1;
      bus.block_in = blk;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.block_in = ~blk;
      cyc = 1;
      for (int t = 0; t < 64; t++) begin
         check($sformatf("%s_vld%0d", name, t), bus.w_valid, 32'd1);
         check($sformatf("%s_idx%0d", name, t), bus.w_idx, t);
         check($sformatf("%s_w%0d", name, t), bus.w_out, expw[t]);
         gotw[t] = bus.w_out;
         if (t == abort_at) begin
            clr_n = 1'b0;
            #1;
            check({name, "_rst_ready"}, bus.ready, 32'd1);
            check({name, "_rst_vld"}, bus.w_valid, 32'd0);
            check({name, "_rst_done"}, bus.done, 32'd0);
            check({name, "_rst_wout"}, bus.w_out, 32'd0);
            check({name, "_rst_idx"}, bus.w_idx, 32'd0);
            repeat (3) begin
               @(negedge clk);
               check({name, "_rst_hold_done"}, bus.done, 32'd0);
               check({name, "_rst_hold_vld"}, bus.w_valid, 32'd0);
            end
            clr_n = 1'b1;
            return;
         end
         if (t == stall_at) begin
            bus.w_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               cyc++;
               check($sformatf("%s_stall_vld%0d", name, t), bus.w_valid, 32'd1);
               check($sformatf("%s_stall_idx%0d", name, t), bus.w_idx, t);
               check($sformatf("%s_stall_w%0d", name, t), bus.w_out, expw[t]);
            end
            bus.w_ready = 1'b1;
         end
         if (t == inj_at) begin
            bus.start    = 1'b1;
            bus.block_in = blk_c;
         end
         @(negedge clk);
         cyc++;
         bus.start    = 1'b0;
         bus.block_in = ~blk;
      end
      check({name, "_done"}, bus.done, 32'd1);
      check({name, "_done_vld"}, bus.w_valid, 32'd0);
      check({name, "_done_wout"}, bus.w_out, 32'd0);
      check({name, "_done_ready"}, bus.ready, 32'd0);
      done_cyc = cyc;
      @(negedge clk);
      check({name, "_post_done"}, bus.done, 32'd0);
      check({name, "_post_ready"}, bus.ready, 32'd1);
   endtask

   initial begin
      blk_abc  = '0;
      blk_abc[511:480] = 32'h61626380;
      blk_abc[31:0]    = 32'h00000018;
      blk_zero = '0;
      for (int i = 0; i < 16; i++) blk_c[511 - 32*i -: 32] = 32'h11111111 * (i + 1);

      clr_n        = 1'b0;
      bus.start    = 1'b0;
      bus.block_in = '0;
      bus.w_ready  = 1'b1;
      #12;
      check("reset_ready", bus.ready, 32'd1);
      check("reset_vld", bus.w_valid, 32'd0);
      check("reset_done", bus.done, 32'd0);
      check("reset_wout", bus.w_out, 32'd0);
      check("reset_idx", bus.w_idx, 32'd0);
      @(negedge clk);
      clr_n = 1'b1;

      // "abc" block with no backpressure. The first start comes right after reset release.
      run_seq("abc", blk_abc, -1, -1, -1);
      check("abc_w0", gotw[0], 32'h61626380);
      check("abc_w15", gotw[15], 32'h00000018);
      check("abc_w16", gotw[16], 32'h61626380);
      check("abc_w17", gotw[17], 32'h000F0000);
      check("abc_w18", gotw[18], 32'h7DA86405);
      check("abc_done_cycle", done_cyc, 32'd65);

      // All-zero block, started in the cycle after the previous done.
      run_seq("zero", blk_zero, -1, -1, -1);
      check("zero_w63", gotw[63], 32'd0);
      check("zero_done_cycle", done_cyc, 32'd65);

      // Three stall cycles at W[20].
      run_seq("stall", blk_abc, 20, -1, -1);
      check("stall_w17", gotw[17], 32'h000F0000);
      check("stall_w18", gotw[18], 32'h7DA86405);
      check("stall_done_cycle", done_cyc, 32'd68);

      // A start with a different block at W[10] must be ignored.
      run_seq("inj", blk_abc, -1, 10, -1);
      check("inj_w16", gotw[16], 32'h61626380);
      check("inj_w18", gotw[18], 32'h7DA86405);

      // Abort by reset at W[30], then a new block.
      run_seq("abort", blk_abc, -1, -1, 30);
      run_seq("after_rst", blk_c, -1, -1, -1);
      check("after_rst_w0", gotw[0], 32'h11111111);
      check("after_rst_w15", gotw[15], 32'h11111110);

      // Back-to-back: "abc" starts in the cycle right after the previous done.
      run_seq("b2b", blk_abc, -1, -1, -1);
      check("b2b_w0", gotw[0], 32'h61626380);
      check("b2b_w17", gotw[17], 32'h000F0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 The block SHALL have no parameters; the window depth (16) and round count (64) are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to load a new 512-bit message block; sampled only when ready=1.
REQ-005 block_in  input  512  message block, word M[0] at [511:480] through M[15] at [31:0].
REQ-006 ready  output  1  high when idle and able to accept start.
REQ-007 w_valid  output  1  W word presented on w_out.
REQ-008 w_ready  input  1  downstream round-register stage accepts the current word.
REQ-009 w_out  output  32  schedule word W[t].
REQ-010 w_idx  output  6  index t of the word on w_out.
REQ-011 done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE, with ready=1 only in IDLE.
REQ-013 In IDLE, start=1 at a clock edge SHALL load M[0..15] into a 16-entry by 32-bit window, set t=0 and enter RUN.
REQ-014 In RUN, the block SHALL present w_valid=1, w_out=window[0] and w_idx=t.
REQ-015 On a transfer (w_valid & w_ready) the block SHALL shift the window down one entry, write new entry 15 = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0] mod 2^32, and increment t.
REQ-016 sigma0(x) SHALL equal ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) SHALL equal ROTR17 ^ ROTR19 ^ SHR10.
REQ-017 Words computed after W[63] SHALL be discarded; w_idx SHALL NOT wrap past 63.
REQ-018 While w_valid=1 and w_ready=0, w_out, w_idx and the window SHALL hold unchanged.
REQ-019 A transfer with t=63 SHALL move the block to DONE.
REQ-020 In DONE, done=1 and w_valid=0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-021 start SHALL be ignored in RUN and DONE; block_in SHALL be ignored except at the load edge.
REQ-022 Latency: W[0] SHALL be valid in the cycle after the start edge; with w_ready held high, the 64 words SHALL appear on 64 consecutive cycles and done SHALL assert in the following cycle.
REQ-023 start asserted in the cycle after done SHALL be accepted, with no dead cycles beyond the DONE state.
REQ-024 w_out SHALL be 0 whenever w_valid=0.

Reset
REQ-025 When clr_n=0, the block SHALL immediately enter IDLE: ready=1, w_valid=0, done=0, w_out=0, w_idx=0, window all zero.
REQ-026 Reset asserted during RUN or DONE SHALL abort the block without a done pulse.
REQ-027 After clr_n rises, the first start SHALL be honoured at the first clock edge.

Verification
REQ-028 "abc" padded block (M[0]=0x61626380, M[15]=0x00000018, others 0), w_ready=1 -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[18]=0x7DA86405, done on cycle 65 after start.
REQ-029 All-zero block -> 64 words all 0x00000000 with w_idx 0..63 in order, then a single done pulse.
REQ-030 Backpressure: drop w_ready for 3 cycles at w_idx=20 -> w_out and w_idx stable for those 3 cycles, and the full W sequence matches REQ-028.
REQ-031 start pulsed at w_idx=10 with a different block_in -> ignored, and the sequence is unchanged.
REQ-032 clr_n pulsed low at w_idx=30 -> outputs reach reset values asynchronously with no done; a new start then yields W[0] of the new block one cycle later.
REQ-033 Back-to-back operation: start in the cycle after done with a second block -> W[0] of the second block appears in the following cycle.
